// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the cache-to-memory arbiter.
// Client ids, write-lock state encoding and the memory bus geometry.
package mem_arb_pkg;

    localparam int unsigned CPU_ADDR_BITS  = 32;
    localparam int unsigned MEM_DATA_BITS  = 128;
    localparam int unsigned MEM_DATA_BYTES = MEM_DATA_BITS / 8;
    localparam int unsigned MEM_ADDR_BITS  = CPU_ADDR_BITS - $clog2(MEM_DATA_BYTES);

    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    typedef enum logic {
        WIDLE = 1'b0,
        WDATA = 1'b1
    } wstate_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned ceil_log2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory-side port: request, write-data and read-response channels.
// master drives requests and write data; slave accepts them and returns responses.
interface mem_arbiter_if;

    logic                                      req_val;
    logic                                      req_rdy;
    logic [mem_arb_pkg::MEM_ADDR_BITS-1:0]     req_addr;
    logic                                      req_rw;
    logic                                      req_data_valid;
    logic                                      req_data_ready;
    logic [mem_arb_pkg::MEM_DATA_BITS-1:0]     req_data_bits;
    logic [mem_arb_pkg::MEM_DATA_BYTES-1:0]    req_data_mask;
    logic                                      resp_val;
    logic [mem_arb_pkg::MEM_DATA_BITS-1:0]     resp_data;

    modport master (
        output req_val, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
        input  req_rdy, req_data_ready, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
        output req_rdy, req_data_ready, resp_val, resp_data
    );

endinterface

// File: rtl/mem_arb_owner_fifo.sv
// In-order record of which client owns each outstanding read.
// 1-bit wide, DEPTH entries; a push while full is ignored.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic pop_id,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = ceil_log2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [DEPTH-1:0] slots_q;
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_id  = slots_q[rptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                slots_q[wptr_q] <= push_id;
                wptr_q          <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the icache and dcache memory ports onto one memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dc has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BEATS       = 4,
    parameter int unsigned OUTSTANDING = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem
);

    localparam int unsigned BeatW = ceil_log2(BEATS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    logic             sel;
    logic             cand_valid, cand_rw, blocked, gnt, fire;
    wstate_e          wstate_q;
    logic             wowner_q, wlock;
    logic [BeatW-1:0] wbeat_q, rbeat_q;
    logic             own_valid, data_fire;
    logic             fifo_full, fifo_empty, fifo_head, push, pop, resp_hit;

`ifdef MEM_ARB_RR_EN
    logic rr_q;

    assign sel = (ic.req_val && dc.req_val) ? rr_q : (dc.req_val ? CLIENT_DC : CLIENT_IC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= CLIENT_DC;
        end else if (fire) begin
            rr_q <= ~sel;
        end
    end
`else
    assign sel = dc.req_val ? CLIENT_DC : CLIENT_IC;
`endif

    // Request channel; every valid/ready is held low while reset is asserted.
    assign cand_valid = (ic.req_val | dc.req_val) & reset;
    assign cand_rw    = (sel == CLIENT_DC) ? dc.req_rw : ic.req_rw;
    assign blocked    = wlock | (~cand_rw & fifo_full);
    assign gnt        = cand_valid & ~blocked;
    assign fire       = gnt & mem.req_rdy;
    assign push       = fire & ~cand_rw;

    assign mem.req_val  = gnt;
    assign mem.req_rw   = cand_valid & cand_rw;
    assign mem.req_addr = !cand_valid ? '0 : (sel == CLIENT_DC) ? dc.req_addr : ic.req_addr;
    assign ic.req_rdy   = fire & (sel == CLIENT_IC);
    assign dc.req_rdy   = fire & (sel == CLIENT_DC);

    // Write-data channel is only open to the latched owner while locked.
    assign wlock     = (wstate_q == WDATA);
    assign own_valid = (wowner_q == CLIENT_DC) ? dc.req_data_valid : ic.req_data_valid;
    assign data_fire = mem.req_data_valid & mem.req_data_ready;

    assign mem.req_data_valid = wlock & own_valid;
    assign mem.req_data_bits  = !wlock ? '0 :
                                (wowner_q == CLIENT_DC) ? dc.req_data_bits : ic.req_data_bits;
    assign mem.req_data_mask  = !wlock ? '0 :
                                (wowner_q == CLIENT_DC) ? dc.req_data_mask : ic.req_data_mask;
    assign ic.req_data_ready  = wlock & (wowner_q == CLIENT_IC) & mem.req_data_ready;
    assign dc.req_data_ready  = wlock & (wowner_q == CLIENT_DC) & mem.req_data_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstate_q <= WIDLE;
            wowner_q <= CLIENT_IC;
            wbeat_q  <= '0;
        end else begin
            unique case (wstate_q)
                WIDLE: begin
                    if (fire && cand_rw) begin
                        wstate_q <= WDATA;
                        wowner_q <= sel;
                        wbeat_q  <= '0;
                    end
                end
                WDATA: begin
                    if (data_fire) begin
                        if (wbeat_q == LastBeat) begin
                            wstate_q <= WIDLE;
                            wbeat_q  <= '0;
                        end else begin
                            wbeat_q <= wbeat_q + BeatW'(1);
                        end
                    end
                end
                default: wstate_q <= WIDLE;
            endcase
        end
    end

    // Response beats go to the oldest outstanding reader; beats with no reader are dropped.
    assign resp_hit = mem.resp_val & ~fifo_empty & reset;
    assign pop      = resp_hit & (rbeat_q == LastBeat);

    assign ic.resp_val  = resp_hit & (fifo_head == CLIENT_IC);
    assign dc.resp_val  = resp_hit & (fifo_head == CLIENT_DC);
    assign ic.resp_data = reset ? mem.resp_data : '0;
    assign dc.resp_data = reset ? mem.resp_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbeat_q <= '0;
        end else if (resp_hit) begin
            rbeat_q <= pop ? '0 : rbeat_q + BeatW'(1);
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (sel),
        .pop     (pop),
        .pop_id  (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
